// File: rtl/kgp_pkg.sv
// ---------------------------------------------------------------------------
// kgp_pkg
// Shared definitions for the KGP multi-cycle sequencer:
//   - state_e      : FSM state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT)
//   - DEF_*        : default widths / reset PC / wait-state limit
// No ports; imported by kgp_sat_counter and kgp_mc_sequencer.
// ---------------------------------------------------------------------------
package kgp_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam int DEF_PC_W     = 8;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_MAX_WAIT = 15;
    localparam int DEF_CNT_W    = 32;

endpackage

// File: rtl/kgp_sat_counter.sv
// ---------------------------------------------------------------------------
// kgp_sat_counter
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping. Used for the cycle and retired-instruction performance counters.
// Ports:
//   clock    in   1   rising-edge clock
//   clr_i    in   1   synchronous clear (wins over en_i)
//   en_i     in   1   count enable
//   count_o  out  W   current count
// ---------------------------------------------------------------------------
module kgp_sat_counter
    import kgp_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clock,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/kgp_mc_sequencer.sv
// ---------------------------------------------------------------------------
// kgp_mc_sequencer
// Multi-cycle control unit and PC for the KGP RISC core. One FSM walks each
// instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB], handshaking
// with instruction and data memories, timing out stuck requests into HALT,
// and keeping saturating cycle / retired-instruction counters.
// Ports:
//   clock, rst                      clock and synchronous active-high reset
//   imem_req/imem_addr/imem_ack/imem_data   instruction fetch handshake
//   ir                              instruction register
//   is_mem/is_store/writes_reg/is_halt      decoder class bits (DECODE..WB)
//   br_taken/br_target              branch unit result (sampled in EXEC)
//   dmem_req/dmem_we/dmem_ack       data memory handshake
//   flag_we/reg_we                  ALU flag and register-file write strobes
//   pc/ra                           current PC and return address (pc+1)
//   halted/bus_err                  HALT indication, sticky timeout flag
//   cycle_cnt/instr_cnt             saturating performance counters
// ---------------------------------------------------------------------------
module kgp_mc_sequencer
    import kgp_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             rst,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    output logic [31:0]      ir,
    input  logic             is_mem,
    input  logic             is_store,
    input  logic             writes_reg,
    input  logic             is_halt,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             flag_we,
    output logic             reg_we,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  ra,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              br_taken_q, br_taken_d;
    logic [PC_W-1:0]   br_target_q, br_target_d;
    logic              bus_err_q, bus_err_d;
    logic              retire;

    // When retiring straight out of EXEC the branch result has not been
    // latched yet, so take it from the live branch-unit inputs.
    logic              br_sel;
    logic [PC_W-1:0]   tgt_sel;

    assign br_sel  = (state_q == EXEC) ? br_taken  : br_taken_q;
    assign tgt_sel = (state_q == EXEC) ? br_target : br_target_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        wait_d      = '0;          // clears on any state change
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        bus_err_d   = bus_err_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        flag_we     = 1'b0;
        reg_we      = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                state_d = is_halt ? HALT : EXEC;
            end
            EXEC: begin
                flag_we     = 1'b1;
                br_taken_d  = br_taken;
                br_target_d = br_target;
                if (is_mem) begin
                    state_d = MEM;
                end else if (writes_reg) begin
                    state_d = WB;
                end else begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        if (retire) begin
            pc_d = br_sel ? tgt_sel : (pc_q + PC_W'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= PC_W'(RESET_PC);
            ir_q        <= '0;
            wait_q      <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            wait_q      <= wait_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            bus_err_q   <= bus_err_d;
        end
    end

    kgp_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock   (clock),
        .clr_i   (rst),
        .en_i    (state_q != HALT),
        .count_o (cycle_cnt)
    );

    kgp_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clock   (clock),
        .clr_i   (rst),
        .en_i    (retire),
        .count_o (instr_cnt)
    );

    assign dmem_we   = dmem_req & is_store;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ra        = pc_q + PC_W'(1);
    assign ir        = ir_q;
    assign halted    = (state_q == HALT);
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_kgp_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kgp_mc_sequencer
// Self-checking bench for kgp_mc_sequencer. Two instances share stimulus: one
// with default 32-bit counters and one with 3-bit counters so saturation is
// reachable. Each instruction is described by its class bits and ack delays;
// the expected per-cycle strobes and the architectural end state are derived
// from instruction latency arithmetic, not from a copy of the FSM.
// ---------------------------------------------------------------------------
module tb_kgp_mc_sequencer;

    localparam int PC_W  = 8;
    localparam int MAXW  = 15;
    localparam int CNT_W = 32;
    localparam int SAT_W = 3;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    logic             imem_ack, is_mem, is_store, writes_reg, is_halt, br_taken, dmem_ack;
    logic [31:0]      imem_data;
    logic [PC_W-1:0]  br_target;

    logic             imem_req, dmem_req, dmem_we, flag_we, reg_we, halted, bus_err;
    logic [PC_W-1:0]  imem_addr, pc, ra;
    logic [31:0]      ir;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    logic             imem_req_s, dmem_req_s, dmem_we_s, flag_we_s, reg_we_s, halted_s, bus_err_s;
    logic [PC_W-1:0]  imem_addr_s, pc_s, ra_s;
    logic [31:0]      ir_s;
    logic [SAT_W-1:0] cycle_cnt_s, instr_cnt_s;

    kgp_mc_sequencer dut (
        .clock(clock), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .is_mem(is_mem), .is_store(is_store), .writes_reg(writes_reg), .is_halt(is_halt),
        .br_taken(br_taken), .br_target(br_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .flag_we(flag_we), .reg_we(reg_we), .pc(pc), .ra(ra),
        .halted(halted), .bus_err(bus_err), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    kgp_mc_sequencer #(.CNT_W(SAT_W)) dut_sat (
        .clock(clock), .rst(rst),
        .imem_req(imem_req_s), .imem_addr(imem_addr_s), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir_s), .is_mem(is_mem), .is_store(is_store), .writes_reg(writes_reg), .is_halt(is_halt),
        .br_taken(br_taken), .br_target(br_target),
        .dmem_req(dmem_req_s), .dmem_we(dmem_we_s), .dmem_ack(dmem_ack),
        .flag_we(flag_we_s), .reg_we(reg_we_s), .pc(pc_s), .ra(ra_s),
        .halted(halted_s), .bus_err(bus_err_s), .cycle_cnt(cycle_cnt_s), .instr_cnt(instr_cnt_s)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural state only.
    logic [PC_W-1:0] m_pc;
    logic [31:0]     m_ir;
    longint          m_ic, m_cc;
    logic            m_halted, m_berr;

    function automatic longint sat_to(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = '0;
        m_ir     = '0;
        m_ic     = 0;
        m_cc     = 0;
        m_halted = 1'b0;
        m_berr   = 1'b0;
    endtask

    task automatic randomize_inputs();
        imem_ack   = 1'($urandom);
        imem_data  = $urandom;
        is_mem     = 1'($urandom);
        is_store   = 1'($urandom);
        writes_reg = 1'($urandom);
        is_halt    = 1'($urandom);
        br_taken   = 1'($urandom);
        br_target  = PC_W'($urandom);
        dmem_ack   = 1'($urandom);
    endtask

    // Strobe vector order: {imem_req, dmem_req, dmem_we, flag_we, reg_we}.
    task automatic check_arch();
        logic [4:0] exp_s;
        exp_s = m_halted ? 5'b00000 : 5'b10000;
        check("pc",        pc,        m_pc);
        check("ra",        ra,        PC_W'(m_pc + 1'b1));
        check("ir",        ir,        m_ir);
        check("halted",    halted,    m_halted);
        check("bus_err",   bus_err,   m_berr);
        check("instr_cnt", instr_cnt, sat_to(m_ic, CNT_W));
        check("cycle_cnt", cycle_cnt, sat_to(m_cc, CNT_W));
        check("idle_strobes", {imem_req, dmem_req, dmem_we, flag_we, reg_we}, exp_s);
        check("pc_s",        pc_s,        m_pc);
        check("halted_s",    halted_s,    m_halted);
        check("bus_err_s",   bus_err_s,   m_berr);
        check("ir_s",        ir_s,        m_ir);
        check("ra_s",        ra_s,        PC_W'(m_pc + 1'b1));
        check("instr_cnt_s", instr_cnt_s, sat_to(m_ic, SAT_W));
        check("cycle_cnt_s", cycle_cnt_s, sat_to(m_cc, SAT_W));
        check("idle_strobes_s", {imem_req_s, dmem_req_s, dmem_we_s, flag_we_s, reg_we_s}, exp_s);
    endtask

    task automatic do_reset();
        @(negedge clock);
        randomize_inputs();
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        model_reset();
        check_arch();
    endtask

    // Run one instruction. iw/dw: cycles before imem/dmem ack (>= MAXW means
    // never acked). rst_at: cycle index at which rst is raised, -1 for none.
    task automatic run_instr(input int iw, input int dw, input bit mem, input bit st,
                             input bit wr, input bit hlt, input bit tk,
                             input logic [PC_W-1:0] tgt, input int rst_at);
        bit         i_to, d_to, wb_ok, stopped, in_mem;
        int         fetch_len, m_first, mem_len, len;
        logic [31:0] word;
        logic [4:0]  exp_s;

        i_to      = (iw >= MAXW);
        d_to      = mem && !st ? (dw >= MAXW) : (mem && (dw >= MAXW));
        fetch_len = i_to ? MAXW : iw + 1;
        m_first   = iw + 3;
        mem_len   = d_to ? MAXW : dw + 1;
        if (i_to)       len = MAXW;
        else if (hlt)   len = iw + 2;
        else if (mem)   len = m_first + mem_len + ((d_to || st) ? 0 : 1);
        else            len = iw + 3 + (wr ? 1 : 0);
        wb_ok   = !i_to && !hlt && !d_to && ((mem && !st) || (!mem && wr));
        stopped = 1'b0;
        word    = '0;

        for (int c = 0; c < len; c++) begin
            @(negedge clock);
            randomize_inputs();
            if (c < fetch_len) begin
                imem_ack = !i_to && (c == iw);
                if (imem_ack) word = imem_data;
            end
            if (!i_to && c >= iw + 1) begin
                is_mem = mem; is_store = st; writes_reg = wr; is_halt = hlt;
            end
            if (!i_to && !hlt && c == iw + 2) begin
                br_taken = tk; br_target = tgt;
            end
            in_mem = !i_to && !hlt && mem && (c >= m_first) && (c < m_first + mem_len);
            if (in_mem) dmem_ack = !d_to && (c == m_first + dw);
            if (c == rst_at) rst = 1'b1;
            #1;
            exp_s = {c < fetch_len, in_mem, in_mem && st,
                     !i_to && !hlt && (c == iw + 2), wb_ok && (c == len - 1)};
            check("strobes",   {imem_req, dmem_req, dmem_we, flag_we, reg_we}, exp_s);
            check("strobes_s", {imem_req_s, dmem_req_s, dmem_we_s, flag_we_s, reg_we_s}, exp_s);
            check("imem_addr",   imem_addr,   m_pc);
            check("imem_addr_s", imem_addr_s, m_pc);
            check("busy_halted", halted, 1'b0);
            @(posedge clock);
            if (c == rst_at) begin
                #1;
                rst = 1'b0;
                model_reset();
                stopped = 1'b1;
                break;
            end
        end

        if (!stopped) begin
            #1;
            m_cc += len;
            if (!i_to) m_ir = word;
            if (i_to || d_to) begin
                m_halted = 1'b1;
                m_berr   = 1'b1;
            end else if (hlt) begin
                m_halted = 1'b1;
            end else begin
                m_pc = tk ? tgt : PC_W'(m_pc + 1'b1);
                m_ic++;
            end
        end
        check_arch();
    endtask

    // While halted, every input is noise: nothing may move.
    task automatic idle_halted(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            randomize_inputs();
            #1;
            check("halt_strobes", {imem_req, dmem_req, dmem_we, flag_we, reg_we}, 5'b00000);
            @(posedge clock);
        end
        #1;
        check_arch();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        randomize_inputs();
        model_reset();

        // ALU op, zero-wait: 4 cycles, reg_we in the last one.
        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 0, 8'h00, -1);

        // Load, imem after 2 waits, dmem after 3 waits: retires at cycle 10.
        do_reset();
        run_instr(2, 3, 1, 0, 1, 0, 0, 8'h00, -1);

        // Branch to 0xFF, taken branch at 0xFF, then non-taken wrap at 0xFF.
        run_instr(0, 0, 0, 0, 0, 0, 1, 8'hFF, -1);
        run_instr(0, 0, 0, 0, 0, 0, 1, 8'h10, -1);
        run_instr(1, 0, 0, 0, 0, 0, 1, 8'hFF, -1);
        run_instr(0, 0, 0, 0, 0, 0, 0, 8'h33, -1);

        // Store zero-wait, and a taken branch carried through MEM/WB.
        run_instr(0, 0, 1, 1, 0, 0, 0, 8'h00, -1);
        run_instr(0, 2, 1, 0, 0, 0, 1, 8'h80, -1);
        run_instr(1, 1, 1, 1, 1, 0, 1, 8'h42, -1);

        // Acks exactly on the last allowed wait cycle.
        run_instr(14, 0, 0, 0, 1, 0, 0, 8'h00, -1);
        run_instr(0, 14, 1, 1, 0, 0, 0, 8'h00, -1);

        // imem timeout: HALT with bus_err, later acks ignored, rst clears.
        run_instr(20, 0, 0, 0, 1, 0, 0, 8'h00, -1);
        idle_halted(6);
        do_reset();

        // dmem timeout during a load.
        run_instr(1, 15, 1, 0, 1, 0, 0, 8'h00, -1);
        idle_halted(3);
        do_reset();

        // Halt instruction: HALT without bus_err.
        run_instr(0, 0, 0, 0, 1, 0, 0, 8'h00, -1);
        run_instr(1, 0, 0, 0, 0, 1, 0, 8'h00, -1);
        idle_halted(4);
        do_reset();

        // Reset in the middle of a waiting store.
        run_instr(0, 0, 0, 0, 1, 0, 0, 8'h00, -1);
        run_instr(1, 6, 1, 1, 0, 0, 0, 8'h00, 6);

        // Randomised instruction stream.
        for (int k = 0; k < 150; k++) begin
            run_instr($urandom_range(0, 4), $urandom_range(0, 4),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                      1'($urandom), PC_W'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
